// File: rtl/flatten_buffer.sv
// flatten_buffer: stores every pooled pixel of every kernel during FILL,
// then replays the whole frame as one kernel-major serial stream in DRAIN.
//
// Output handshake: a word transfers on any rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_data and out_last hold stable. out_valid never drops before the
// transfer except on res.
// The input side has no stall: in_ready only reports FILL/DRAIN, and pixels
// offered outside FILL (or beyond a full kernel map) are dropped and raise
// the sticky overflow flag.
module flatten_buffer #(
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2,
  parameter int BitSize            = 8,
  parameter int ImageWidth         = 4
) (
  input  logic                                         clk,
  input  logic                                         res,
  input  logic [NumberOfK-1:0]                         in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
  input  logic                                         in_set_done,
  output logic                                         in_ready,
  output logic                                         out_valid,
  output logic [BitSize-1:0]                           out_data,
  output logic                                         out_last,
  input  logic                                         out_ready,
  output logic                                         overflow,
  output logic                                         fsm_state
);

  localparam int Pixels = ImageWidth * ImageWidth;
  localparam int Depth  = NumberOfK * Pixels;
  localparam int AW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW     = $clog2(Pixels + 1);

  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);
  localparam logic [CW-1:0] FullCnt  = CW'(Pixels);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [BitSize-1:0]   mem [Depth];
  logic [CW-1:0]        wcnt [NumberOfK];
  logic [AW-1:0]        raddr;
  logic [NumberOfK-1:0] wr_en;
  logic [NumberOfK-1:0] wr_drop;
  logic                 fire;
  logic                 last_fire;

  assign fsm_state = state;
  assign fire      = out_valid && out_ready;
  assign last_fire = fire && out_last;

  // Per-kernel write enables, and pixels that must be discarded as overflow
  always_comb begin
    wr_en   = '0;
    wr_drop = '0;
    for (int k = 0; k < NumberOfK; k++) begin
      wr_en[k]   = (state == FILL) && in_valid[k] && (wcnt[k] != FullCnt);
      wr_drop[k] = in_valid[k] && ((state == DRAIN) || (wcnt[k] == FullCnt));
    end
  end

  // Frame storage: each kernel owns its own Pixels-deep slice, so parallel writes never collide
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumberOfK; k++) begin
      if (wr_en[k] && !res) begin
        mem[AW'(k * Pixels) + AW'(wcnt[k])] <= in_data[k % ProcessingElements];
      end
    end
  end

  // Per-kernel pixel counters, rewound when a frame has been fully drained
  always_ff @(posedge clk) begin
    if (res || last_fire) begin
      for (int k = 0; k < NumberOfK; k++) begin
        wcnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumberOfK; k++) begin
        if (wr_en[k]) begin
          wcnt[k] <= wcnt[k] + CW'(1);
        end
      end
    end
  end

  // Read pointer: parked at 0 during FILL, advances on each accepted word
  always_ff @(posedge clk) begin
    if (res) begin
      raddr <= '0;
    end else if (state == FILL) begin
      raddr <= '0;
    end else if (fire) begin
      raddr <= (raddr == LastAddr) ? '0 : raddr + AW'(1);
    end
  end

  // Sticky overflow: any dropped pixel sets it until reset
  always_ff @(posedge clk) begin
    if (res) begin
      overflow <= 1'b0;
    end else if (|wr_drop) begin
      overflow <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (res) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: set-done starts the drain, the last handshake ends it
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (in_set_done) state_next = DRAIN;
      DRAIN:   if (last_fire)   state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // FSM outputs: data is zeroed outside DRAIN so the unreset memory never leaks out
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (raddr == LastAddr);
        out_data  = mem[raddr];
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_flatten_buffer.sv
// Bench for flatten_buffer: drives frames kernel-pair by kernel-pair, keeps a
// frame-level reference (pixel store plus per-kernel fill counts) and checks
// the drained stream word by word.
module tb_flatten_buffer;

  localparam int NK    = 8;
  localparam int PE    = 2;
  localparam int BW    = 8;
  localparam int IW    = 4;
  localparam int PIX   = IW * IW;
  localparam int DEPTH = NK * PIX;

  logic                   clk = 1'b0;
  logic                   res;
  logic [NK-1:0]          in_valid;
  logic [PE-1:0][BW-1:0]  in_data;
  logic                   in_set_done;
  logic                   in_ready;
  logic                   out_valid;
  logic [BW-1:0]          out_data;
  logic                   out_last;
  logic                   out_ready;
  logic                   overflow;
  logic                   fsm_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model: what each kernel has received this frame
  logic [BW-1:0] ref_mem [DEPTH];
  int            ref_cnt [NK];
  bit            ref_ovf;
  bit            ref_drain;
  logic [BW-1:0] exp_q[$];

  always #5 clk = ~clk;

  flatten_buffer #(
    .NumberOfK(NK), .ProcessingElements(PE), .BitSize(BW), .ImageWidth(IW)
  ) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
    .in_set_done(in_set_done), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) ref_cnt[k] = 0;
    ref_ovf   = 1'b0;
    ref_drain = 1'b0;
  endtask

  task automatic apply_reset();
    res = 1'b1;
    in_valid = '0; in_set_done = 1'b0; out_ready = 1'b1;
    step();
    step();
    res = 1'b0;
    model_reset();
  endtask

  // one input cycle; the model applies the frame rules to the same stimulus
  task automatic fill_cycle(input logic [NK-1:0] mask, input logic [BW-1:0] d0,
                            input logic [BW-1:0] d1, input bit sd);
    in_valid = mask; in_data[0] = d0; in_data[1] = d1; in_set_done = sd;
    for (int k = 0; k < NK; k++) begin
      if (mask[k]) begin
        if (ref_drain || ref_cnt[k] == PIX) begin
          ref_ovf = 1'b1;
        end else begin
          ref_mem[k * PIX + ref_cnt[k]] = (k % 2 == 1) ? d1 : d0;
          ref_cnt[k]++;
        end
      end
    end
    if (sd) ref_drain = 1'b1;
    step();
    in_valid = '0; in_set_done = 1'b0;
  endtask

  // sd_mode: 0 = separate set-done strobe, 1 = set-done with last pair, 2 = no set-done
  task automatic fill_frame(input bit rand_data, input int npix, input int sd_mode);
    logic [NK-1:0] m;
    logic [BW-1:0] d0, d1;
    for (int j = 0; j < NK / 2; j++) begin
      for (int p = 0; p < npix; p++) begin
        m  = 8'h03 << (2 * j);
        d0 = rand_data ? BW'($urandom_range(0, 255)) : BW'((2 * j) * PIX + p);
        d1 = rand_data ? BW'($urandom_range(0, 255)) : BW'((2 * j + 1) * PIX + p);
        fill_cycle(m, d0, d1, (sd_mode == 1) && (j == NK / 2 - 1) && (p == npix - 1));
      end
    end
    if (sd_mode == 0) fill_cycle('0, '0, '0, 1'b1);
  endtask

  // drain the frame and compare every word against the model's kernel-major order
  task automatic drain(input bit random_ready, input int poke_at, input int abort_after);
    int idx = 0;
    int budget = 0;
    bit stalled = 1'b0;
    bit poked = 1'b0;
    bit done = 1'b0;
    logic [BW-1:0] prev_d;
    logic prev_l;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_mem[i]);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL first_valid: out_valid=%b required 1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== ref_ovf) $display("FAIL ovf_at_drain_start: got %b required %b", overflow, ref_ovf);
    else pass_cnt++;
    while (!done && budget < 4000) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == poke_at && !poked) begin
        in_valid = 8'h01; in_data[0] = 8'hA5; ref_ovf = 1'b1; poked = 1'b1;
      end else begin
        in_valid = '0;
      end
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL drain_valid idx=%0d: valid=%b ready=%b required 1/0", idx, out_valid, in_ready);
      end else begin
        pass_cnt++;
        if (stalled) begin
          total_cnt++;
          if (out_data !== prev_d || out_last !== prev_l)
            $display("FAIL stall_hold idx=%0d: data=%h last=%b required %h/%b", idx, out_data, out_last, prev_d, prev_l);
          else pass_cnt++;
        end
        total_cnt++;
        if (out_data !== exp_q[idx])
          $display("FAIL drain_data idx=%0d: got %h required %h", idx, out_data, exp_q[idx]);
        else pass_cnt++;
        total_cnt++;
        if (out_last !== (idx == DEPTH - 1))
          $display("FAIL drain_last idx=%0d: got %b required %b", idx, out_last, idx == DEPTH - 1);
        else pass_cnt++;
      end
      if (out_ready) begin
        idx++;
        stalled = 1'b0;
        if (idx == DEPTH) done = 1'b1;
      end else begin
        stalled = 1'b1; prev_d = out_data; prev_l = out_last;
      end
      step();
      budget++;
      if (abort_after > 0 && idx == abort_after) break;
    end
    in_valid = '0;
    out_ready = 1'b1;
    if (abort_after > 0 && idx == abort_after) return;
    total_cnt++;
    if (!done) begin
      $display("FAIL drain_timeout: words=%0d required %0d", idx, DEPTH);
      return;
    end
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL fill_resume: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else pass_cnt++;
    ref_drain = 1'b0;
    for (int k = 0; k < NK; k++) ref_cnt[k] = 0;
    total_cnt++;
    if (overflow !== ref_ovf) $display("FAIL ovf_after_drain: got %b required %b", overflow, ref_ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    res = 1'b1; in_valid = '0; in_data = '0; in_set_done = 1'b0; out_ready = 1'b0;
    step();
    step();
    total_cnt++;
    if ({out_valid, out_last, out_data, in_ready, overflow, fsm_state} !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: v=%b l=%b d=%h r=%b o=%b s=%b required 0 0 00 1 0 0",
               out_valid, out_last, out_data, in_ready, overflow, fsm_state);
    else pass_cnt++;
    res = 1'b0;
    model_reset();
  endtask

  task automatic test_full_frame();
    fill_frame(1'b0, PIX, 0);
    drain(1'b0, -1, 0);
  endtask

  task automatic test_backpressure();
    fill_frame(1'b0, PIX, 0);
    drain(1'b1, -1, 0);
    fill_frame(1'b1, PIX, 0);
    drain(1'b1, -1, 0);
  endtask

  task automatic test_set_done_with_write();
    fill_frame(1'b0, PIX, 1);
    total_cnt++;
    if (ref_mem[DEPTH - 1] !== 8'd127) $display("FAIL model_last: got %0d required 127", ref_mem[DEPTH - 1]);
    else pass_cnt++;
    drain(1'b0, -1, 0);
  endtask

  task automatic test_overflow();
    fill_frame(1'b1, PIX, 2);
    fill_cycle(8'h08, 8'h00, 8'hEE, 1'b0);
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow_set: got %b required 1", overflow);
    else pass_cnt++;
    fill_cycle('0, '0, '0, 1'b1);
    drain(1'b1, -1, 0);
  endtask

  task automatic test_write_during_drain();
    apply_reset();
    fill_frame(1'b1, PIX, 0);
    drain(1'b1, 60, 0);
    fill_frame(1'b1, PIX, 0);
    drain(1'b0, -1, 0);
    apply_reset();
    fill_frame(1'b1, PIX, 0);
    drain(1'b0, DEPTH - 1, 0);
  endtask

  task automatic test_short_frame();
    apply_reset();
    fill_frame(1'b1, PIX / 2, 0);
    drain(1'b1, -1, 0);
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    fill_frame(1'b1, PIX, 0);
    drain(1'b0, -1, 50);
    res = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || fsm_state !== 1'b0)
      $display("FAIL reset_mid_drain: valid=%b ready=%b state=%b required 0/1/0", out_valid, in_ready, fsm_state);
    else pass_cnt++;
    res = 1'b0;
    model_reset();
    fill_frame(1'b1, PIX, 1);
    drain(1'b1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_set_done_with_write();
    test_overflow();
    test_write_during_drain();
    test_short_frame();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
